cordic_out_stage: RTL and testbench

CORDIC_OUT_STAGE -- requirements
Module: cordic_out_stage

---
 rtl/cordic_out_stage_pkg.sv | 35 +++
 rtl/sync_fifo.sv | 54 +++++
 rtl/cordic_out_stage.sv | 94 +++++++++
 tb/tb_cordic_out_stage.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_out_stage_pkg.sv
// Shared constants and types for the CORDIC output stage: gain, arctangent table,
// and the packed sample record that travels through the output FIFO.
package cordic_out_stage_pkg;

  localparam int DATA_W = 16;
  localparam int SEL_W  = 4;

  // 0.60736 in Q1.15: the accumulated gain after 6 CORDIC iterations.
  localparam logic [DATA_W-1:0] K_GAIN_DEF = 16'h4DBE;

  // atan(2^-i) in degrees, signed 8.8
  localparam logic [DATA_W-1:0] ATAN_0 = 16'h2D00;  // 45.00
  localparam logic [DATA_W-1:0] ATAN_1 = 16'h1A92;  // 26.57
  localparam logic [DATA_W-1:0] ATAN_2 = 16'h0E0A;  // 14.04
  localparam logic [DATA_W-1:0] ATAN_3 = 16'h0721;  //  7.13
  localparam logic [DATA_W-1:0] ATAN_4 = 16'h0394;  //  3.58
  localparam logic [DATA_W-1:0] ATAN_5 = 16'h01CA;  //  1.79

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] angle;
    logic [DATA_W-1:0] y;
    logic [DATA_W-1:0] x;
  } sample_t;

  localparam int SAMPLE_W = $bits(sample_t);

  // Round-half-up back to 8.8; |K_GAIN| < 1 so the low 16 bits never overflow.
  function automatic logic [DATA_W-1:0] round_q15(input logic signed [31:0] p);
    logic signed [31:0] r;
    r = (p + 32'sd16384) >>> 15;
    return r[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage; head is read combinationally from
// storage so it holds steady while the consumer stalls.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointers are exactly AW bits wide, so the increment wraps modulo DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cordic_out_stage.sv
// Gain correction (x,y * K_GAIN) over two non-stalling stages into an output FIFO;
// pipe_en grants credit only while the FIFO can absorb everything in flight.
module cordic_out_stage
  import cordic_out_stage_pkg::*;
#(
  parameter int                DEPTH  = 4,
  parameter logic [DATA_W-1:0] K_GAIN = K_GAIN_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      x_in,
  input  logic [DATA_W-1:0]      y_in,
  input  logic [DATA_W-1:0]      angle_in,
  input  logic [SEL_W-1:0]       select_in,
  output logic                   pipe_en,
  output logic [DATA_W-1:0]      x_out,
  output logic [DATA_W-1:0]      y_out,
  output logic [DATA_W-1:0]      angle_out,
  output logic [SEL_W-1:0]       select_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic                     s1_valid_q;
  logic signed [31:0]       s1_x_q, s1_y_q;
  logic [DATA_W-1:0]        s1_angle_q;
  logic [SEL_W-1:0]         s1_sel_q;
  logic                     s2_valid_q;
  sample_t                  s2_q;

  logic                     accept;
  logic [CW:0]              credit;
  logic signed [31:0]       x_prod_d, y_prod_d;
  sample_t                  head;
  logic                     fifo_empty;
  logic                     fifo_full;

  // One extra bit: occupancy plus two in-flight samples can exceed DEPTH's range.
  assign credit  = {1'b0, count} + (CW+1)'(s1_valid_q) + (CW+1)'(s2_valid_q);
  assign pipe_en = (credit < (CW+1)'(DEPTH));
  assign accept  = in_valid && pipe_en;

  assign x_prod_d = $signed({{16{x_in[15]}}, x_in}) * $signed({16'h0000, K_GAIN});
  assign y_prod_d = $signed({{16{y_in[15]}}, y_in}) * $signed({16'h0000, K_GAIN});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_angle_q <= '0;
      s1_sel_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_q       <= '0;
    end else begin
      s1_valid_q <= accept;
      s1_x_q     <= x_prod_d;
      s1_y_q     <= y_prod_d;
      s1_angle_q <= angle_in;
      s1_sel_q   <= select_in;
      s2_valid_q <= s1_valid_q;
      s2_q.x     <= round_q15(s1_x_q);
      s2_q.y     <= round_q15(s1_y_q);
      s2_q.angle <= s1_angle_q;
      s2_q.sel   <= s1_sel_q;
    end
  end

  sync_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s2_valid_q),
    .din   (s2_q),
    .pop   (out_ready),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  assign out_valid  = !fifo_empty;
  assign x_out      = head.x;
  assign y_out      = head.y;
  assign angle_out  = head.angle;
  assign select_out = head.sel;

endmodule

// File: tb/tb_cordic_out_stage.sv
// Bench for cordic_out_stage: directed vector table, scoreboard on every pop,
// and hand sequences for backpressure, wrap, throughput and mid-flight reset.
module tb_cordic_out_stage;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [15:0]   x_in, y_in, angle_in;
  logic [3:0]    select_in;
  logic          pipe_en;
  logic [15:0]   x_out, y_out, angle_out;
  logic [3:0]    select_out;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;

  int tests = 0;
  int fails = 0;

  logic [51:0] exp_q[$];

  typedef struct {
    logic [15:0] x, y, ang;
    logic [3:0]  sel;
    logic [15:0] ex, ey;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  cordic_out_stage #(.DEPTH(DEPTH), .K_GAIN(16'h4DBE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .x_in       (x_in),
    .y_in       (y_in),
    .angle_in   (angle_in),
    .select_in  (select_in),
    .pipe_en    (pipe_en),
    .x_out      (x_out),
    .y_out      (y_out),
    .angle_out  (angle_out),
    .select_out (select_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .count      (count)
  );

  // Reference: floor((v * 0.60736 * 32768 + 16384) / 32768), computed in reals.
  function automatic logic [15:0] model(input logic [15:0] v);
    real r;
    int  q;
    r = $itor($signed(v)) * 19902.0;
    q = $rtoi($floor((r + 16384.0) / 32768.0));
    return q[15:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand();
    x_in      = 16'($urandom_range(0, 65535));
    y_in      = 16'($urandom_range(0, 65535));
    angle_in  = 16'($urandom_range(0, 65535));
    select_in = 4'($urandom_range(0, 15));
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((out_valid || exp_q.size() != 0) && n < 60) begin
      step();
      n++;
    end
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    check({name, "_count0"}, 64'(count), 64'd0);
  endtask

  // Scoreboard: expected pushed at acceptance, compared at each pop.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (in_valid && pipe_en)
        exp_q.push_back({select_in, angle_in, model(y_in), model(x_in)});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected: got %0h expected none", {select_out, angle_out, y_out, x_out});
        end else begin
          check("sb_head", 64'({select_out, angle_out, y_out, x_out}), 64'(exp_q.pop_front()));
        end
      end
      if (dut.s2_valid_q && dut.u_fifo.full) begin
        fails++;
        $display("FAIL push_full: got push with count %0d expected no push", count);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, first_block, cnt_at_block, steady_bad;

    vecs[0] = '{16'h0100, 16'h0000, 16'h2D00, 4'h1, 16'h009B, 16'h0000};
    vecs[1] = '{16'hFF00, 16'h8000, 16'h1A92, 4'h2, 16'hFF65, 16'hB242};
    vecs[2] = '{16'h7FFF, 16'h0001, 16'h0E0A, 4'h3, 16'h4DBD, 16'h0001};
    vecs[3] = '{16'h0000, 16'hFFFF, 16'hF8DF, 4'hE, 16'h0000, 16'hFFFF};
    vecs[4] = '{16'h0200, 16'hFE00, 16'h01CA, 4'hF, 16'h0137, 16'hFEC9};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    x_in = '0; y_in = '0; angle_in = '0; select_in = '0;
    step();
    step();
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_x_out", 64'(x_out), 64'd0);
    rst_n = 1'b1;
    check("rst_pipe_en", 64'(pipe_en), 64'd1);

    // Directed vectors: latency of 3 edges and a single-cycle out_valid.
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      x_in = vecs[i].x; y_in = vecs[i].y; angle_in = vecs[i].ang; select_in = vecs[i].sel;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check("vec_lat1", 64'(out_valid), 64'd0);
      step();
      check("vec_lat2", 64'(out_valid), 64'd0);
      step();
      check("vec_valid", 64'(out_valid), 64'd1);
      check("vec_x", 64'(x_out), 64'(vecs[i].ex));
      check("vec_y", 64'(y_out), 64'(vecs[i].ey));
      check("vec_angle", 64'(angle_out), 64'(vecs[i].ang));
      check("vec_sel", 64'(select_out), 64'(vecs[i].sel));
      step();
      check("vec_one_cycle", 64'(out_valid), 64'd0);
    end

    // Backpressure: exactly DEPTH accepted, credit closes with 2 still in flight.
    out_ready = 1'b0;
    acc = 0; first_block = -1; cnt_at_block = -1;
    for (int i = 0; i < 16; i++) begin
      drive_rand();
      in_valid = 1'b1;
      if (pipe_en) acc++;
      else if (first_block < 0) begin
        first_block = i;
        cnt_at_block = int'(count);
      end
      step();
    end
    check("fill_accepted", 64'(acc), 64'(DEPTH));
    check("fill_block_cycle", 64'(first_block), 64'(DEPTH));
    check("fill_block_count", 64'(cnt_at_block), 64'(DEPTH - 2));
    check("fill_count", 64'(count), 64'(DEPTH));
    check("fill_pipe_en", 64'(pipe_en), 64'd0);
    check("fill_head_valid", 64'(out_valid), 64'd1);

    // One pop while full, credit reopens, then drain across the pointer wrap.
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("pop1_count", 64'(count), 64'(DEPTH - 1));
    check("pop1_pipe_en", 64'(pipe_en), 64'd1);
    drive_rand();
    step();
    in_valid = 1'b0;
    step(); step(); step();
    check("refill_count", 64'(count), 64'(DEPTH));
    drain("wrap");

    // Streaming: one sample per cycle, occupancy settles at 1.
    out_ready = 1'b1;
    acc = 0; steady_bad = 0;
    for (int i = 0; i < 40; i++) begin
      drive_rand();
      in_valid = 1'b1;
      if (pipe_en) acc++;
      step();
      if (i >= 2 && count != CW'(1)) steady_bad++;
    end
    in_valid = 1'b0;
    check("stream_accepted", 64'(acc), 64'd40);
    check("stream_steady", 64'(steady_bad), 64'd0);
    drain("stream");

    // Reset with 3 queued and 2 in flight.
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin drive_rand(); step(); end
    in_valid = 1'b0;
    step(); step();
    check("pre_rst_count", 64'(count), 64'd3);
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin drive_rand(); step(); end
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_rst_count", 64'(count), 64'd0);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_pipe_en", 64'(pipe_en), 64'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_no_stale", 64'(out_valid), 64'd0);
    end
    out_ready = 1'b1;
    x_in = 16'h0100; y_in = 16'hFF00; angle_in = 16'h0394; select_in = 4'h7;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    check("post_rst_x", 64'(x_out), 64'h009B);
    check("post_rst_y", 64'(y_out), 64'hFF65);
    drain("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
